// File: rtl/snake_body_engine_if.sv
// Control, status and renderer-read signals between the game FSM, the VGA renderer
// and the snake body engine.
interface snake_body_engine_if #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 16
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  logic          update_snake;
  logic          reset_game;
  logic [1:0]    direction_in;
  logic [XW-1:0] food_x;
  logic [YW-1:0] food_y;
  logic [IW-1:0] seg_rd_idx;
  logic [XW-1:0] seg_rd_x;
  logic [YW-1:0] seg_rd_y;
  logic          seg_rd_valid;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          busy;
  logic          food_eaten;
  logic          collision;
  logic          overrun;

  modport master (
    output update_snake, reset_game, direction_in, food_x, food_y, seg_rd_idx,
    input  seg_rd_x, seg_rd_y, seg_rd_valid, head_x, head_y, length,
    input  busy, food_eaten, collision, overrun
  );

  modport slave (
    input  update_snake, reset_game, direction_in, food_x, food_y, seg_rd_idx,
    output seg_rd_x, seg_rd_y, seg_rd_valid, head_x, head_y, length,
    output busy, food_eaten, collision, overrun
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake segment store: advances one cell per update request, scans serially for
// self collision, detects walls and food, and serves a combinational read port.
module snake_body_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 12
) (
  input  logic              clk,
  input  logic              rst,
  snake_body_engine_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  localparam logic [1:0]    DIR_UP    = 2'b00;
  localparam logic [1:0]    DIR_RIGHT = 2'b01;
  localparam logic [1:0]    DIR_DOWN  = 2'b10;
  localparam logic [1:0]    DIR_LEFT  = 2'b11;
  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
  localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_HEAD   = 3'd2,
    ST_SCAN   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_DEAD   = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  logic [XW-1:0] seg_x_r [MAX_LEN];
  logic [YW-1:0] seg_y_r [MAX_LEN];
  logic [LW-1:0] length_r;
  logic [1:0]    dir_r;
  logic [XW-1:0] nxt_x_r;
  logic [YW-1:0] nxt_y_r;
  logic          eat_r;
  logic          hit_r;
  logic [LW-1:0] scan_idx_r;
  logic [LW-1:0] scan_n_r;
  logic          busy_r;
  logic          food_eaten_r;
  logic          collision_r;
  logic          overrun_r;

  logic [XW-1:0] cand_x_s;
  logic [YW-1:0] cand_y_s;
  logic          wall_s;
  logic          cand_eat_s;
  logic          scan_hit_s;
  logic          scan_last_s;
  logic          reversal_s;
  logic [1:0]    dir_sel_s;

  // A request opposite to the latched heading is dropped and the heading kept.
  assign reversal_s = (bus.direction_in == (dir_r ^ 2'b10));
  assign dir_sel_s  = reversal_s ? dir_r : bus.direction_in;

  assign cand_eat_s  = (cand_x_s == bus.food_x) && (cand_y_s == bus.food_y);
  assign scan_hit_s  = (seg_x_r[scan_idx_r[IW-1:0]] == nxt_x_r) &&
                       (seg_y_r[scan_idx_r[IW-1:0]] == nxt_y_r);
  assign scan_last_s = ((scan_idx_r + LW'(1)) == scan_n_r);

  // Candidate head one step along the latched heading, flagging a step off the grid.
  always_comb begin
    cand_x_s = seg_x_r[0];
    cand_y_s = seg_y_r[0];
    wall_s   = 1'b0;
    case (dir_r)
      DIR_UP: begin
        if (seg_y_r[0] == YW'(0)) begin
          wall_s = 1'b1;
        end else begin
          cand_y_s = seg_y_r[0] - YW'(1);
        end
      end
      DIR_RIGHT: begin
        if (seg_x_r[0] == X_MAX) begin
          wall_s = 1'b1;
        end else begin
          cand_x_s = seg_x_r[0] + XW'(1);
        end
      end
      DIR_DOWN: begin
        if (seg_y_r[0] == Y_MAX) begin
          wall_s = 1'b1;
        end else begin
          cand_y_s = seg_y_r[0] + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_x_r[0] == XW'(0)) begin
          wall_s = 1'b1;
        end else begin
          cand_x_s = seg_x_r[0] - XW'(1);
        end
      end
      default: begin
        wall_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; reset_game overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.reset_game) begin
      state_nxt_s = ST_INIT;
    end else begin
      case (state_r)
        ST_INIT: begin
          state_nxt_s = ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.update_snake) begin
            state_nxt_s = ST_HEAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HEAD: begin
          if (wall_s) begin
            state_nxt_s = ST_DEAD;
          end else begin
            state_nxt_s = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!scan_last_s) begin
            state_nxt_s = ST_SCAN;
          end else if (hit_r || scan_hit_s) begin
            state_nxt_s = ST_DEAD;
          end else begin
            state_nxt_s = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_nxt_s = ST_IDLE;
        end
        ST_DEAD: begin
          state_nxt_s = ST_DEAD;
        end
        default: begin
          state_nxt_s = ST_INIT;
        end
      endcase
    end
  end

  // State register; reset lands directly in IDLE because reset also loads the start image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Segment store: start image on reset/INIT, single-edge shift on COMMIT.
  always_ff @(posedge clk) begin
    if (rst || (state_r == ST_INIT)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_r[i] <= XW'(INIT_X - i);
          seg_y_r[i] <= YW'(INIT_Y);
        end else begin
          seg_x_r[i] <= XW'(0);
          seg_y_r[i] <= YW'(0);
        end
      end
      length_r <= LEN_INIT;
    end else if ((state_r == ST_COMMIT) && !bus.reset_game) begin
      for (int i = MAX_LEN - 1; i > 0; i--) begin
        seg_x_r[i] <= seg_x_r[i-1];
        seg_y_r[i] <= seg_y_r[i-1];
      end
      seg_x_r[0] <= nxt_x_r;
      seg_y_r[0] <= nxt_y_r;
      if (eat_r && (length_r < LEN_MAX)) begin
        length_r <= length_r + LW'(1);
      end
    end
  end

  // Heading, scan bookkeeping and the status flags reported to the game FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r        <= DIR_RIGHT;
      nxt_x_r      <= XW'(0);
      nxt_y_r      <= YW'(0);
      eat_r        <= 1'b0;
      hit_r        <= 1'b0;
      scan_idx_r   <= LW'(0);
      scan_n_r     <= LW'(0);
      busy_r       <= 1'b0;
      food_eaten_r <= 1'b0;
      collision_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      food_eaten_r <= 1'b0;
      if (bus.reset_game && (state_r != ST_INIT)) begin
        busy_r <= 1'b0;
      end else begin
        if (bus.update_snake && (busy_r || (state_r == ST_DEAD))) begin
          overrun_r <= 1'b1;
        end
        case (state_r)
          ST_INIT: begin
            dir_r       <= DIR_RIGHT;
            busy_r      <= 1'b0;
            collision_r <= 1'b0;
            overrun_r   <= 1'b0;
          end
          ST_IDLE: begin
            if (bus.update_snake) begin
              dir_r  <= dir_sel_s;
              busy_r <= 1'b1;
            end
          end
          ST_HEAD: begin
            if (wall_s) begin
              collision_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              nxt_x_r    <= cand_x_s;
              nxt_y_r    <= cand_y_s;
              eat_r      <= cand_eat_s;
              hit_r      <= 1'b0;
              scan_idx_r <= LW'(0);
              // When eating, the tail stays put, so it is a valid obstacle too.
              scan_n_r   <= cand_eat_s ? length_r : (length_r - LW'(1));
            end
          end
          ST_SCAN: begin
            hit_r      <= hit_r | scan_hit_s;
            scan_idx_r <= scan_idx_r + LW'(1);
            if (scan_last_s && (hit_r || scan_hit_s)) begin
              collision_r <= 1'b1;
              busy_r      <= 1'b0;
            end
          end
          ST_COMMIT: begin
            busy_r       <= 1'b0;
            food_eaten_r <= eat_r;
          end
          default: begin
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Renderer read port, out-of-range indices read as zero.
  always_comb begin
    if (LW'(bus.seg_rd_idx) < length_r) begin
      bus.seg_rd_valid = 1'b1;
      bus.seg_rd_x     = seg_x_r[bus.seg_rd_idx];
      bus.seg_rd_y     = seg_y_r[bus.seg_rd_idx];
    end else begin
      bus.seg_rd_valid = 1'b0;
      bus.seg_rd_x     = XW'(0);
      bus.seg_rd_y     = YW'(0);
    end
  end

  assign bus.head_x     = seg_x_r[0];
  assign bus.head_y     = seg_y_r[0];
  assign bus.length     = length_r;
  assign bus.busy       = busy_r;
  assign bus.food_eaten = food_eaten_r;
  assign bus.collision  = collision_r;
  assign bus.overrun    = overrun_r;
endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

- Holds the snake's segment list and advances it one grid cell per `update_snake` pulse from the game FSM.
- Detects wall and self collisions and food consumption, and reports them back as `collision` and `food_eaten`, closing the FSM ↔ body loop.
- Exposes a random-access segment read port for the VGA renderer.
- Multi-cycle: the self-collision scan is serial, one segment per clock.

## Interface
- `GRID_W`, 32: grid columns; x ∈ [0, GRID_W-1].
- `GRID_H`, 24: grid rows; y ∈ [0, GRID_H-1].
- `MAX_LEN`, 16: segment storage depth (≥ INIT_LEN).
- `INIT_LEN`, 3: length after reset (≥ 2).
- `INIT_X`, 16: initial head x; body extends to −x (requires INIT_X ≥ INIT_LEN-1).
- `INIT_Y`, 12: initial row.
- Derived widths: XW = clog2(GRID_W), YW = clog2(GRID_H), LW = clog2(MAX_LEN+1), IW = clog2(MAX_LEN).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `update_snake`  in  1  one-cycle advance request.
- `reset_game`  in  1  level; while high, snake is held at its initial image.
- `direction_in`  in  2  encoding: 00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1).
- `food_x` / `food_y`  in  XW / YW  current food cell.
- `seg_rd_idx`  in  IW  renderer read index (0 = head).
- `seg_rd_x` / `seg_rd_y` / `seg_rd_valid`  out  XW / YW / 1  combinational read; valid = idx < length, else 0 / 0 / 0.
- `head_x` / `head_y`  out  XW / YW  segment 0.
- `length`  out  LW  current segment count.
- `busy`  out  1  advance in progress.
- `food_eaten`  out  1  one-cycle pulse.
- `collision`  out  1  level, sticky until re-init.
- `overrun`  out  1  sticky; `update_snake` arrived while busy or in DEAD.

## Operation
States: INIT, IDLE, HEAD, SCAN, COMMIT, DEAD.

- **INIT**
  - Loads seg[i] = (INIT_X−i, INIT_Y) for i < INIT_LEN; length = INIT_LEN.
  - Latched dir = right; collision = 0; overrun = 0.
  - Next state: IDLE.
- **IDLE**
  - On `update_snake`: latch `direction_in`, except a reversal of the latched dir (up↔down, left↔right), which is ignored and the old dir kept.
  - Sets busy = 1; next state HEAD.
- **HEAD**
  - Computes next head nxt from seg[0] and dir.
  - wall = moving past x = 0, x = GRID_W−1, y = 0 or y = GRID_H−1.
  - wall → DEAD (body unchanged). Otherwise register nxt, set eat = (nxt == food), scan_idx = 0, go to SCAN.
- **SCAN**
  - Each cycle: compare seg[scan_idx] with nxt, OR the result into hit, then scan_idx++.
  - Compare count N = length−1 normally; N = length when eat (tail does not vacate).
  - After N compares: hit → DEAD, else → COMMIT.
- **COMMIT**
  - Shift seg[i+1] ← seg[i]; seg[0] ← nxt.
  - If eat: pulse food_eaten; length++ saturating at MAX_LEN. At MAX_LEN the tail is dropped.
  - Next state: IDLE.
- **DEAD**
  - collision = 1; busy = 0; `update_snake` ignored (sets overrun).
- **Priority:** `rst` > `reset_game` (from any state → INIT, pending advance discarded) > `update_snake`.

## Timing
- Reset values:
  - seg image and length as in INIT; head = (INIT_X, INIT_Y).
  - busy = 0, food_eaten = 0, collision = 0, overrun = 0.
  - State IDLE (reset performs the INIT load directly).
- Normal advance, with the sampling edge counted as edge 1:
  - busy = 1 after edge 1.
  - HEAD occupies cycle 2; SCAN occupies N cycles; COMMIT occupies 1 cycle.
  - New head, length and food_eaten are visible, and busy = 0, after edge N+3.
  - Example: length 3, no food → N = 2 → 5 edges.
- Wall collision: collision = 1 and busy = 0 after edge 2; head unchanged.
- Self collision: collision = 1 after edge N+2; no shift occurs.
- `reset_game` asserted: INIT after the next edge, IDLE after the following edge; collision drops after the INIT edge.
- An `update_snake` pulse coincident with the edge that leaves COMMIT is lost and sets overrun.
- The renderer read port is purely combinational and reflects register state only (no mid-shift view, since the shift is a single edge).

## Test plan
- **Straight move:** reset; `update_snake` with dir 01 → after 5 edges head = (17,12), seg2 = (15,12), length = 3, food_eaten = 0.
- **Eat and grow:** food = (17,12); `update_snake` with dir 01 → after 6 edges (N = 3) food_eaten high for exactly 1 cycle, length = 4, seg3 = (14,12).
- **Reversal rejected:** after reset, `update_snake` with dir 11 → head = (17,12) (continues right), no collision.
- **Wall:** drive right from (16,12) 15 times to reach (31,12), then once more → collision = 1 two edges after the sample, head stays (31,12). A further `update_snake` sets overrun. `reset_game` restores head (16,12) and collision = 0.
- **Self collision:** grow to length 5 via food at (17,12) and (18,12), then issue up, left, down → third advance sets collision = 1 after N+2 edges, length stays 5.
- **Saturation and mid-op reset:**
  - With MAX_LEN = 4, eat twice from length 3 → length stays 4, food_eaten still pulses both times.
  - `reset_game` during SCAN → no COMMIT occurs, init image restored.
